// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
// Receive end of the messenger serial link. It aligns to the transmitter's
// frame strobe and deserialises 8 data bits, sent LSB first, after each
// strobe. It flags framing violations and buffers completed bytes in a
// first-word-fall-through FIFO for the incoming monitor.
//
// Optional feature (macro SERIAL_FRAME_RECEIVER_DECRYPT_EN): each assembled
// byte is decrypted with KEY before it is pushed. Latency does not change.
//
// Parameters:
//   DEPTH        FIFO entries (power of 2, >= 2)
//   KEY          link private key (used only with the decrypt feature)
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   serial_in    serial data bit, LSB first
//   frame_strobe transmitter frame-slot indicator (1 cycle per 9-cycle frame)
//   rd_en        consumer pop request
//   rd_data      FIFO head byte (holds last popped value when empty)
//   rd_valid     FIFO not empty
//   count        FIFO occupancy
//   frame_error  one-cycle pulse on a framing violation
//   overflow     sticky, byte dropped because FIFO was full
//   flag_clear   synchronous clear of overflow
// -----------------------------------------------------------------------------
module serial_frame_receiver #(
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  KEY   = 8'd43
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic                     frame_strobe,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_error,
    output logic                     overflow,
    input  logic                     flag_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_RECV = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           frame_error_q, frame_error_d;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     mem_q [DEPTH];

    logic           push_c;
    logic [7:0]     raw_byte_c;
    logic [7:0]     push_byte_c;
    logic           pop_c;
    logic           full_c;
    logic           wr_en_c;
    logic           drop_c;

    // Byte completed on this edge: the bit being sampled lands in position 7.
    assign raw_byte_c = {serial_in, shift_q[6:0]};

`ifdef SERIAL_FRAME_RECEIVER_DECRYPT_EN
    // XOR with the key, invert even bits, permute odd bits.
    function automatic logic [7:0] decrypt(input logic [7:0] d);
        logic [7:0] x;
        logic [7:0] o;
        x    = d ^ KEY;
        o[0] = ~x[0];
        o[2] = ~x[2];
        o[4] = ~x[4];
        o[6] = ~x[6];
        o[1] = x[5];
        o[3] = x[1];
        o[5] = x[3];
        o[7] = x[7];
        return o;
    endfunction

    assign push_byte_c = decrypt(raw_byte_c);
`else
    logic unused_key;
    assign unused_key  = ^KEY;
    assign push_byte_c = raw_byte_c;
`endif

    // Frame alignment and deserialisation.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        frame_error_d = 1'b0;
        push_c        = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (frame_strobe) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'd0;
                end
            end
            ST_RECV: begin
                if (frame_strobe) begin
                    // A strobe inside a partial byte is a violation; it re-aligns.
                    frame_error_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d     = 3'd0;
                    shift_d       = 8'd0;
                end else begin
                    shift_d[bit_cnt_q] = serial_in;
                    if (bit_cnt_q == 3'd7) begin
                        push_c    = 1'b1;
                        state_d   = ST_WAIT;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (frame_strobe) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'd0;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = ST_HUNT;
                end
            end
            default: begin
                state_d   = ST_HUNT;
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
            end
        endcase
    end

    // FIFO bookkeeping; head register is precomputed so rd_data is registered.
    always_comb begin
        pop_c      = rd_en && rd_valid_q;
        full_c     = (count_q == CW'(DEPTH));
        wr_en_c    = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;
        wr_ptr_d   = wr_ptr_q + AW'(wr_en_c);
        rd_ptr_d   = rd_ptr_q + AW'(pop_c);
        count_d    = count_q + CW'(wr_en_c) - CW'(pop_c);
        rd_valid_d = (count_d != CW'(0));
        rd_data_d  = rd_data_q;
        if (count_d != CW'(0)) begin
            // The slot being written is the new head only when the FIFO
            // would otherwise be empty after this cycle's pop.
            if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_d = push_byte_c;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
        overflow_d = overflow_q;
        if (flag_clear) begin
            overflow_d = 1'b0;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            frame_error_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_data_q     <= 8'd0;
            rd_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_byte_c;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule
